// File: rtl/mul_arb_pkg.sv
// rtl/mul_arb_pkg.sv - shared constants, tag-width helper and pipeline entry type for the multiplier arbiter.
package mul_arb_pkg;

  localparam int DW_DEFAULT  = 32;
  // Entry fields are sized for the widest supported configuration (8 requesters, 64-bit data).
  localparam int PIPE_TAG_W  = 3;
  localparam int PIPE_DATA_W = 64;

  function automatic int tag_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic                   valid;
    logic [PIPE_TAG_W-1:0]  tag;
    logic [PIPE_DATA_W-1:0] data;
  } pipe_entry_t;

endpackage

// File: rtl/mul_pipe.sv
// rtl/mul_pipe.sv - fixed-latency pipelined unsigned multiplier carrying a valid bit and tag with the data.
module mul_pipe
  import mul_arb_pkg::*;
#(
  parameter int DW    = DW_DEFAULT,
  parameter int TAG_W = 2,
  parameter int LAT   = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic [TAG_W-1:0] issue_tag,
  input  logic [DW-1:0]    a,
  input  logic [DW-1:0]    b,
  output logic             done_valid,
  output logic [TAG_W-1:0] done_tag,
  output logic [DW-1:0]    product,
  output logic             busy
);

  logic             s1_valid;
  logic [TAG_W-1:0] s1_tag;
  logic [DW-1:0]    s1_a;
  logic [DW-1:0]    s1_b;
  logic [DW-1:0]    prod;
  pipe_entry_t      last;
  logic             tail_busy;

  // Data registers load only with a valid entry so the output product holds between results.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_tag   <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else begin
      s1_valid <= issue_valid;
      if (issue_valid) begin
        s1_tag <= issue_tag;
        s1_a   <= a;
        s1_b   <= b;
      end
    end
  end

  assign prod = s1_a * s1_b;

  generate
    if (LAT == 1) begin : g_single
      assign last = '{valid: s1_valid, tag: PIPE_TAG_W'(s1_tag), data: PIPE_DATA_W'(prod)};
      assign tail_busy = 1'b0;
    end else begin : g_multi
      pipe_entry_t stage [2:LAT];

      always_ff @(posedge clock) begin
        if (reset) begin
          for (int k = 2; k <= LAT; k++) begin
            stage[k] <= '0;
          end
        end else begin
          stage[2].valid <= s1_valid;
          if (s1_valid) begin
            stage[2].tag  <= PIPE_TAG_W'(s1_tag);
            stage[2].data <= PIPE_DATA_W'(prod);
          end
          for (int k = 3; k <= LAT; k++) begin
            stage[k].valid <= stage[k-1].valid;
            if (stage[k-1].valid) begin
              stage[k].tag  <= stage[k-1].tag;
              stage[k].data <= stage[k-1].data;
            end
          end
        end
      end

      always_comb begin
        tail_busy = 1'b0;
        for (int k = 2; k <= LAT; k++) begin
          tail_busy = tail_busy | stage[k].valid;
        end
      end

      assign last = stage[LAT];
    end
  endgenerate

  assign done_valid = last.valid;
  assign done_tag   = last.tag[TAG_W-1:0];
  assign product    = last.data[DW-1:0];
  assign busy       = s1_valid | tail_busy;

  logic unused_last;
  assign unused_last = ^{last.tag, last.data};

endmodule

// File: rtl/mul_rr_arbiter.sv
// rtl/mul_rr_arbiter.sv - round-robin front end sharing one mul_pipe between NUM_REQ requesters.
// Optional MUL_ARB_STATS_EN adds saturating issue_count and collision_count outputs.
module mul_rr_arbiter
  import mul_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int MUL_LAT = 2,
  parameter int DW      = DW_DEFAULT
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0][DW-1:0]  req_a,
  input  logic [NUM_REQ-1:0][DW-1:0]  req_b,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_REQ-1:0]          resp_valid,
  output logic [DW-1:0]               resp_data,
  output logic                        busy
`ifdef MUL_ARB_STATS_EN
  ,
  output logic [31:0]                 issue_count,
  output logic [31:0]                 collision_count
`endif
);

  localparam int TAG_W = tag_w(NUM_REQ);

  logic [TAG_W-1:0] ptr;
  logic [TAG_W-1:0] grant_idx;
  logic             grant_any;
  logic             done_valid;
  logic [TAG_W-1:0] done_tag;
  logic [DW-1:0]    product;
  logic             pipe_busy;

  // Grant is withheld during reset so req_ready reads zero regardless of req_valid.
  always_comb begin
    int idx;
    idx       = 0;
    req_ready = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!grant_any && !reset && req_valid[idx]) begin
        grant_any      = 1'b1;
        grant_idx      = TAG_W'(idx);
        req_ready[idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr <= '0;
    end else if (grant_any) begin
      ptr <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + TAG_W'(1);
    end
  end

  mul_pipe #(
    .DW    (DW),
    .TAG_W (TAG_W),
    .LAT   (MUL_LAT)
  ) u_pipe (
    .clock       (clock),
    .reset       (reset),
    .issue_valid (grant_any),
    .issue_tag   (grant_idx),
    .a           (req_a[grant_idx]),
    .b           (req_b[grant_idx]),
    .done_valid  (done_valid),
    .done_tag    (done_tag),
    .product     (product),
    .busy        (pipe_busy)
  );

  always_comb begin
    resp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      resp_valid[i] = done_valid && (done_tag == TAG_W'(i));
    end
  end

  assign resp_data = product;
  assign busy      = pipe_busy;

`ifdef MUL_ARB_STATS_EN
  logic multi_req;

  // Clearing the lowest set bit leaves a nonzero value only when two or more requests are up.
  assign multi_req = (req_valid & (req_valid - NUM_REQ'(1))) != '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      issue_count     <= '0;
      collision_count <= '0;
    end else begin
      if (grant_any && issue_count != '1) begin
        issue_count <= issue_count + 32'd1;
      end
      if (multi_req && collision_count != '1) begin
        collision_count <= collision_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/mul_rr_arbiter.md
Name: mul_rr_arbiter

Overview:
- Shares one pipelined 32-bit multiplier between NUM_REQ requesters.
- Uses a round-robin grant with a valid/ready handshake on the request side.
- Carries the requester tag through the pipeline and returns each product to its originator with fixed latency.
- Sits in front of the cube/power datapaths so several clients reuse one multiplier pipeline instead of instantiating their own.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MUL_LAT, 2, multiplier pipeline depth in cycles (>=1).
- DW, 32, operand and result width.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_a  input  NUM_REQ x DW  per-requester operand A (packed array, index i).
- req_b  input  NUM_REQ x DW  per-requester operand B.
- req_ready  output  NUM_REQ  one-hot grant; handshake completes when req_valid[i] and req_ready[i] are both high.
- resp_valid  output  NUM_REQ  one-hot: product for requester i is valid this cycle.
- resp_data  output  DW  product, shared by all requesters.
- busy  output  1  high while any pipeline stage holds a valid entry.

Behaviour:
- Reset values:
  - req_ready = 0, resp_valid = 0, resp_data = 0, busy = 0.
  - Round-robin pointer = 0.
  - All pipeline valid bits and tags cleared.
- Grant is combinational from req_valid and the pointer:
  - Search starts at pointer, wraps modulo NUM_REQ; first asserted req_valid wins.
  - req_ready is one-hot or all zero.
  - No request pending -> req_ready = 0 and nothing is issued.
- The multiplier accepts one issue per cycle; the pipeline never stalls, so there is no request-side bubble.
- On a grant to index g in cycle T, the pointer becomes (g+1) mod NUM_REQ at T+1. With no grant, the pointer holds.
- Issued entry = {valid=1, tag=g, a, b}. Stage 1 registers the operands; stages 2..MUL_LAT carry the product and tag.
- Latency: resp_valid[g] = 1 with resp_data = (a*b)[DW-1:0] in cycle T+MUL_LAT, asserted for exactly one cycle.
  - Requesters must accept; there is no response backpressure.
- Arithmetic: unsigned; the 2*DW product is truncated to the low DW bits; overflow is silent.
- resp_data holds its last value when resp_valid = 0.
- Fairness: each continuously requesting client is granted at least once every NUM_REQ cycles.
- Requester protocol: a requester must hold req_a/req_b stable while req_valid=1 and req_ready=0. Dropping req_valid before the grant is legal, and the arbiter simply skips that requester.
- Simultaneous requests: when all are valid, grants rotate 0,1,2,3,0,... starting from the pointer.
- busy = OR of all stage valid bits. The issue cycle itself is not counted.
- Reset mid-operation: in-flight entries are discarded, no resp_valid is produced for them, and the pointer returns to 0.

Optional Feature:
- Macro: MUL_ARB_STATS_EN.
- Defined:
  - Adds output issue_count [31:0], which increments by 1 on every grant and saturates at 32'hFFFF_FFFF.
  - Adds output collision_count [31:0], which increments on every cycle with two or more req_valid bits high, also saturating.
  - Both counters reset to 0.
- Not defined: neither port nor the counters exist; behaviour is otherwise identical.

Decomposition:
- Shared package mul_arb_pkg:
  - DW default constant.
  - TAG_W = $clog2(NUM_REQ) helper function.
  - pipe_entry_t struct {valid, tag, data}.
- Sub-module mul_pipe:
  - MUL_LAT-stage registered multiplier carrying a valid bit and tag alongside the data.
  - Reusable by other datapaths.
- Arbiter:
  - Round-robin grant logic and pointer register.
  - Response one-hot decode (tag -> resp_valid).
  - Stats counters.

Test Plan:
- Single request: req_valid=4'b0100, a=3, b=7 at cycle 10 -> req_ready=4'b0100 at cycle 10; resp_valid=4'b0100, resp_data=21 at cycle 12; busy high in cycles 11-12.
- All four valid continuously from pointer 0 with distinct operands (i+1)*(i+2) -> grants 0,1,2,3,0 on consecutive cycles; responses 2,6,12,20 on consecutive cycles, each with the matching one-hot resp_valid.
- Overflow: a=32'hFFFF_FFFF, b=2 -> resp_data=32'hFFFF_FFFE after MUL_LAT cycles.
- Fairness: requester 0 held valid continuously, requester 2 asserted later -> requester 2 is granted within 4 cycles, then grants alternate 0,2,0,2.
- Reset mid-flight: reset asserted one cycle after two grants -> no resp_valid follows; pointer = 0; a later single request to index 1 is granted immediately.
- With MUL_ARB_STATS_EN: 5 grants, 3 of them in cycles with 2+ valid requests -> issue_count=5, collision_count=3.
